// File: rtl/ic_addr_router.sv
// Address router between one master and ND devices, with an optional error responder (IC_ADDR_ROUTER_ERR_EN).
// Latency: request path 0 cycles (combinational), response path 1 cycle through a one-entry register.
// Backpressure: m_gnt_o waits on trk_ready_i and the selected d_gnt_i; responses wait until the register is free.
module ic_addr_router #(
    parameter int              ND      = 3,
    parameter int              AW      = 32,
    parameter int              DW      = 32,
    parameter logic [ND*AW-1:0] D_BASE = {32'h4000_0000, 32'h0001_0000, 32'h0000_0000},
    parameter logic [ND*AW-1:0] D_MASK = {32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000},
    parameter int              MAX_ERR = 4
) (
    input  logic                g_clk,
    input  logic                g_resetn,

    input  logic                m_req_i,
    output logic                m_gnt_o,
    input  logic                m_wen_i,
    input  logic [DW/8-1:0]     m_strb_i,
    input  logic [AW-1:0]       m_addr_i,
    input  logic [DW-1:0]       m_wdata_i,
    output logic                m_recv_o,
    input  logic                m_ack_i,
    output logic                m_error_o,
    output logic [DW-1:0]       m_rdata_o,

    output logic [ND-1:0]       d_req_o,
    input  logic [ND-1:0]       d_gnt_i,
    output logic                d_wen_o,
    output logic [DW/8-1:0]     d_strb_o,
    output logic [AW-1:0]       d_addr_o,
    output logic [DW-1:0]       d_wdata_o,
    input  logic [ND-1:0]       d_recv_i,
    output logic [ND-1:0]       d_ack_o,
    input  logic [ND-1:0]       d_error_i,
    input  logic [ND*DW-1:0]    d_rdata_i,

    output logic [ND:0]         trk_requests_o,
    output logic [ND:0]         trk_responses_o,
    input  logic [ND:0]         trk_rsp_gnt_i,
    input  logic                trk_ready_i
);

    logic [ND-1:0] hit;
    logic [ND-1:0] sel;
    logic          dev_gnt;
    logic          free;
    logic          capture;
    logic          src_vld;
    logic          src_err;
    logic [DW-1:0] src_dat;

    logic          rv_q, rv_d;
    logic          re_q, re_d;
    logic [DW-1:0] rd_q, rd_d;

`ifdef IC_ADDR_ROUTER_ERR_EN
    localparam int EW = $clog2(MAX_ERR + 1);

    logic [EW-1:0] err_pend_q, err_pend_d;
    logic          mapped;
    logic          err_acc;
    logic          err_cap;
    logic          err_vld;

    assign mapped  = |hit;
    assign err_acc = m_req_i & trk_ready_i & ~mapped & (err_pend_q < EW'(MAX_ERR));
    assign err_vld = (err_pend_q != '0);
    assign err_cap = capture & trk_rsp_gnt_i[ND];
`endif

    always_comb begin
        for (int i = 0; i < ND; i++) begin
            hit[i] = ((m_addr_i & D_MASK[i*AW +: AW]) == D_BASE[i*AW +: AW]);
        end
    end

    // Lowest matching index wins on overlapping windows.
    always_comb begin
        logic found;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < ND; i++) begin
            if (!found && hit[i]) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
`ifndef IC_ADDR_ROUTER_ERR_EN
        if (!found) begin
            sel[ND-1] = 1'b1;
        end
`endif
    end

    assign d_req_o   = sel & {ND{m_req_i & trk_ready_i}};
    assign dev_gnt   = m_req_i & trk_ready_i & (|(d_gnt_i & sel));
    assign d_wen_o   = m_wen_i;
    assign d_strb_o  = m_strb_i;
    assign d_addr_o  = m_addr_i;
    assign d_wdata_o = m_wdata_i;

    always_comb begin
        src_vld = 1'b0;
        src_err = 1'b0;
        src_dat = '0;
        for (int i = 0; i < ND; i++) begin
            if (trk_rsp_gnt_i[i]) begin
                src_vld = src_vld | d_recv_i[i];
                src_err = src_err | d_error_i[i];
                src_dat = src_dat | d_rdata_i[i*DW +: DW];
            end
        end
`ifdef IC_ADDR_ROUTER_ERR_EN
        if (trk_rsp_gnt_i[ND]) begin
            src_vld = src_vld | err_vld;
            src_err = 1'b1;
        end
`endif
    end

    assign free    = ~rv_q | m_ack_i;
    assign capture = free & src_vld;
    assign d_ack_o = trk_rsp_gnt_i[ND-1:0] & {ND{free}};

    always_comb begin
        rv_d = rv_q;
        re_d = re_q;
        rd_d = rd_q;
        if (capture) begin
            rv_d = 1'b1;
            re_d = src_err;
            rd_d = src_dat;
        end else if (m_ack_i) begin
            rv_d = 1'b0;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            rv_q <= 1'b0;
            re_q <= 1'b0;
            rd_q <= '0;
        end else begin
            rv_q <= rv_d;
            re_q <= re_d;
            rd_q <= rd_d;
        end
    end

    assign m_recv_o  = rv_q;
    assign m_error_o = re_q;
    assign m_rdata_o = rd_q;

`ifdef IC_ADDR_ROUTER_ERR_EN
    always_comb begin
        err_pend_d = err_pend_q;
        if (err_acc && !err_cap) begin
            err_pend_d = err_pend_q + EW'(1);
        end else if (!err_acc && err_cap) begin
            err_pend_d = err_pend_q - EW'(1);
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            err_pend_q <= '0;
        end else begin
            err_pend_q <= err_pend_d;
        end
    end

    assign m_gnt_o         = dev_gnt | err_acc;
    assign trk_requests_o  = {err_acc, sel & {ND{dev_gnt}}};
    assign trk_responses_o = capture ? trk_rsp_gnt_i : '0;
`else
    // The pseudo-device slot is absent, so its grant bit is deliberately ignored.
    logic unused_err_gnt;
    assign unused_err_gnt = trk_rsp_gnt_i[ND];

    assign m_gnt_o         = dev_gnt;
    assign trk_requests_o  = {1'b0, sel & {ND{dev_gnt}}};
    assign trk_responses_o = {1'b0, capture ? trk_rsp_gnt_i[ND-1:0] : {ND{1'b0}}};
`endif

endmodule

// File: tb/tb_ic_addr_router.sv
// Directed plus randomized bench for ic_addr_router against a queue-based reference model.
module tb_ic_addr_router;
    localparam int ND      = 3;
    localparam int DW      = 32;
    localparam int MAX_ERR = 4;

    logic              g_clk = 1'b0;
    logic              g_resetn;
    logic              m_req, m_gnt, m_wen, m_recv, m_ack, m_error;
    logic [3:0]        m_strb;
    logic [31:0]       m_addr, m_wdata, m_rdata;
    logic [ND-1:0]     d_req, d_gnt, d_recv, d_ack, d_error;
    logic              d_wen;
    logic [3:0]        d_strb;
    logic [31:0]       d_addr, d_wdata;
    logic [ND*DW-1:0]  d_rdata;
    logic [ND:0]       trk_requests, trk_responses, trk_rsp_gnt;
    logic              trk_ready;

    ic_addr_router dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .m_req_i(m_req), .m_gnt_o(m_gnt), .m_wen_i(m_wen), .m_strb_i(m_strb),
        .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_recv_o(m_recv), .m_ack_i(m_ack),
        .m_error_o(m_error), .m_rdata_o(m_rdata),
        .d_req_o(d_req), .d_gnt_i(d_gnt), .d_wen_o(d_wen), .d_strb_o(d_strb),
        .d_addr_o(d_addr), .d_wdata_o(d_wdata), .d_recv_i(d_recv), .d_ack_o(d_ack),
        .d_error_i(d_error), .d_rdata_i(d_rdata),
        .trk_requests_o(trk_requests), .trk_responses_o(trk_responses),
        .trk_rsp_gnt_i(trk_rsp_gnt), .trk_ready_i(trk_ready)
    );

    always #5 g_clk = ~g_clk;

    typedef struct {
        logic        err;
        logic [31:0] dat;
    } rsp_t;

    rsp_t rq[$];
    int   err_pend = 0;
    int   checks   = 0;
    int   errors   = 0;

    // Address windows as base/size pairs, searched in index order.
    longint win_base[ND] = '{64'h0000_0000, 64'h0001_0000, 64'h4000_0000};
    longint win_size[ND] = '{64'h0001_0000, 64'h0001_0000, 64'h0000_1000};

    logic [ND-1:0] obs_dreq, obs_dack;
    logic          obs_gnt;
    logic [ND:0]   obs_treq, obs_trsp;

    logic [31:0] seq_dat[3] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        longint ua = {32'b0, a};
        for (int i = 0; i < ND; i++) begin
            if (ua >= win_base[i] && ua < win_base[i] + win_size[i]) return i;
        end
        return ND;
    endfunction

    task automatic idle();
        m_req = 1'b0; m_wen = 1'b0; m_strb = '0; m_addr = '0; m_wdata = '0; m_ack = 1'b0;
        d_gnt = '0; d_recv = '0; d_error = '0; d_rdata = '0;
        trk_rsp_gnt = '0; trk_ready = 1'b1;
    endtask

    // One clock: inputs are already driven after a falling edge.
    task automatic cycle();
        int            dev, owner;
        bit            gnt, free, srcv, cap;
        rsp_t          r;
        logic [ND-1:0] exp_dreq, exp_dack;
        logic [ND:0]   exp_treq, exp_trsp;
        #1;
        dev = decode(m_addr);
`ifndef IC_ADDR_ROUTER_ERR_EN
        if (dev == ND) dev = ND - 1;
`endif
        exp_dreq = '0;
        if (m_req && trk_ready && dev < ND) exp_dreq[dev] = 1'b1;
        if (dev < ND) gnt = m_req && trk_ready && d_gnt[dev];
        else          gnt = m_req && trk_ready && (err_pend < MAX_ERR);
        exp_treq = '0;
        if (gnt) exp_treq[dev] = 1'b1;

        owner = -1;
        for (int i = 0; i <= ND; i++) if (trk_rsp_gnt[i]) owner = i;
        free  = (rq.size() == 0) || m_ack;
        srcv  = 1'b0;
        r.err = 1'b0;
        r.dat = '0;
        if (owner >= 0 && owner < ND) begin
            srcv  = d_recv[owner];
            r.err = d_error[owner];
            r.dat = d_rdata[owner*DW +: DW];
        end
`ifdef IC_ADDR_ROUTER_ERR_EN
        else if (owner == ND) begin
            srcv  = (err_pend > 0);
            r.err = 1'b1;
        end
`endif
        cap      = free && srcv;
        exp_dack = free ? trk_rsp_gnt[ND-1:0] : '0;
        exp_trsp = cap ? trk_rsp_gnt : '0;

        obs_dreq = d_req; obs_gnt = m_gnt; obs_treq = trk_requests;
        obs_dack = d_ack; obs_trsp = trk_responses;
        check("d_req", 32'(d_req), 32'(exp_dreq));
        check("m_gnt", 32'(m_gnt), 32'(gnt));
        check("trk_requests", 32'(trk_requests), 32'(exp_treq));
        check("d_ack", 32'(d_ack), 32'(exp_dack));
        check("trk_responses", 32'(trk_responses), 32'(exp_trsp));
        check("d_addr", d_addr, m_addr);
        check("d_wdata", d_wdata, m_wdata);
        check("d_wen_strb", 32'({d_wen, d_strb}), 32'({m_wen, m_strb}));

        @(posedge g_clk);
        if (!g_resetn) begin
            rq.delete();
            err_pend = 0;
        end else begin
            if (m_ack && rq.size() > 0) rq.delete(0);
            if (cap) rq.push_back(r);
            if (gnt && dev == ND) err_pend++;
            if (cap && owner == ND) err_pend--;
        end
        #1;
        check("m_recv", 32'(m_recv), 32'(rq.size() > 0));
        if (rq.size() > 0) begin
            check("m_error", 32'(m_error), 32'(rq[0].err));
            check("m_rdata", m_rdata, rq[0].dat);
        end
        @(negedge g_clk);
    endtask

    initial begin
        g_resetn = 1'b0;
        idle();
        @(negedge g_clk);
        cycle();
        cycle();
        check("rst_m_recv", 32'(m_recv), 32'd0);
        check("rst_m_error", 32'(m_error), 32'd0);
        check("rst_m_rdata", m_rdata, 32'd0);
        check("rst_comb", 32'({obs_dreq, obs_gnt, obs_treq, obs_dack, obs_trsp}), 32'd0);
        g_resetn = 1'b1;

        // Mapped read to device 1 and its response.
        idle(); m_req = 1'b1; m_addr = 32'h0001_0004; d_gnt = 3'b010;
        cycle();
        check("rd_dreq", 32'(obs_dreq), 32'h2);
        check("rd_gnt", 32'(obs_gnt), 32'h1);
        check("rd_treq", 32'(obs_treq), 32'h2);
        idle(); d_recv = 3'b010; d_rdata[63:32] = 32'hCAFE_0001; trk_rsp_gnt = 4'b0010;
        cycle();
        check("rd_trsp", 32'(obs_trsp), 32'h2);
        check("rd_recv", 32'(m_recv), 32'h1);
        check("rd_rdata", m_rdata, 32'hCAFE_0001);
        idle(); m_ack = 1'b1;
        cycle();
        check("rd_drain", 32'(m_recv), 32'h0);

        // Tracker not ready blocks the request, then grants in the same cycle.
        idle(); trk_ready = 1'b0; m_req = 1'b1; m_addr = 32'h4000_0010; d_gnt = 3'b111;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("blk_dreq", 32'(obs_dreq), 32'h0);
            check("blk_gnt", 32'(obs_gnt), 32'h0);
        end
        trk_ready = 1'b1;
        cycle();
        check("unblk_gnt", 32'(obs_gnt), 32'h1);
        check("unblk_dreq", 32'(obs_dreq), 32'h4);

`ifdef IC_ADDR_ROUTER_ERR_EN
        // Unmapped read answered by the error responder.
        idle(); m_req = 1'b1; m_addr = 32'h2000_0000;
        cycle();
        check("err_gnt", 32'(obs_gnt), 32'h1);
        check("err_treq", 32'(obs_treq), 32'h8);
        idle(); trk_rsp_gnt = 4'b1000;
        cycle();
        check("err_recv", 32'(m_recv), 32'h1);
        check("err_error", 32'(m_error), 32'h1);
        check("err_rdata", m_rdata, 32'h0);
        idle(); m_ack = 1'b1;
        cycle();

        // Outstanding-error limit.
        idle(); m_req = 1'b1; m_addr = 32'h2000_0000;
        for (int k = 0; k < MAX_ERR; k++) begin
            cycle();
            check("lim_gnt", 32'(obs_gnt), 32'h1);
        end
        cycle();
        check("lim_stall", 32'(obs_gnt), 32'h0);
        trk_rsp_gnt = 4'b1000; m_ack = 1'b1;
        cycle();
        check("lim_stall_cap", 32'(obs_gnt), 32'h0);
        cycle();
        check("lim_resume", 32'(obs_gnt), 32'h1);
        m_req = 1'b0;
        repeat (4) cycle();
        check("lim_drain", 32'(m_recv), 32'h0);
`else
        // Unmapped address falls through to the last device.
        idle(); m_req = 1'b1; m_addr = 32'h2000_0000; d_gnt = 3'b100;
        cycle();
        check("dflt_dreq", 32'(obs_dreq), 32'h4);
        check("dflt_treq", 32'(obs_treq), 32'h4);
`endif

        // Out-of-order device response waits for its turn.
        idle(); trk_rsp_gnt = 4'b0001; d_recv = 3'b100; d_rdata[95:64] = 32'hD2D2_0002;
        cycle();
        check("ooo_dack_wait", 32'(obs_dack), 32'h1);
        check("ooo_no_recv", 32'(m_recv), 32'h0);
        d_recv = 3'b101; d_rdata[31:0] = 32'hA0A0_0000;
        cycle();
        check("ooo_dack_d0", 32'(obs_dack), 32'h1);
        check("ooo_rdata_d0", m_rdata, 32'hA0A0_0000);
        trk_rsp_gnt = 4'b0100; m_ack = 1'b1; d_recv = 3'b100;
        cycle();
        check("ooo_dack_d2", 32'(obs_dack), 32'h4);
        check("ooo_rdata_d2", m_rdata, 32'hD2D2_0002);
        idle(); m_ack = 1'b1;
        cycle();

        // Back-to-back responses with m_ack held.
        idle(); m_ack = 1'b1; d_recv = 3'b111; d_rdata = {seq_dat[2], seq_dat[1], seq_dat[0]};
        for (int k = 0; k < 3; k++) begin
            trk_rsp_gnt = 4'(1 << k);
            cycle();
            check("b2b_recv", 32'(m_recv), 32'h1);
            check("b2b_rdata", m_rdata, seq_dat[k]);
        end
        trk_rsp_gnt = '0; d_recv = '0;
        cycle();
        check("b2b_end", 32'(m_recv), 32'h0);

        // Reset while a response is held.
        idle(); d_recv = 3'b001; d_rdata[31:0] = 32'h5A5A_5A5A; trk_rsp_gnt = 4'b0001;
        cycle();
`ifdef IC_ADDR_ROUTER_ERR_EN
        idle(); m_req = 1'b1; m_addr = 32'h2000_0000;
        repeat (MAX_ERR) cycle();
`endif
        g_resetn = 1'b0; idle();
        cycle();
        g_resetn = 1'b1;
        check("mrst_recv", 32'(m_recv), 32'h0);
        check("mrst_rdata", m_rdata, 32'h0);
        check("mrst_error", 32'(m_error), 32'h0);
`ifdef IC_ADDR_ROUTER_ERR_EN
        m_req = 1'b1; m_addr = 32'h2000_0000;
        cycle();
        check("mrst_err_gnt", 32'(obs_gnt), 32'h1);
`endif

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            int k;
            m_req  = 1'($urandom_range(0, 1));
            m_wen  = 1'($urandom_range(0, 1));
            m_strb = 4'($urandom);
            m_wdata = $urandom;
            case ($urandom_range(0, 4))
                0:       m_addr = {16'h0000, 16'($urandom)};
                1:       m_addr = {16'h0001, 16'($urandom)};
                2:       m_addr = 32'h4000_0000 | 32'($urandom_range(0, 'hFFF));
                3:       m_addr = 32'h4000_1000 + 32'($urandom_range(0, 'h10));
                default: m_addr = $urandom;
            endcase
            d_gnt   = 3'($urandom);
            d_recv  = 3'($urandom);
            d_error = 3'($urandom);
            d_rdata = {$urandom, $urandom, $urandom};
            k = $urandom_range(0, 4);
            trk_rsp_gnt = (k == 4) ? 4'b0000 : 4'(1 << k);
            trk_ready = ($urandom_range(0, 3) != 0);
            m_ack     = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ic_addr_router.md
# ic_addr_router

Sits between one master port of the interconnect and ND device ports, next to the response-order tracker. Decodes each master request address to a one-hot device select and forwards the request, reporting every accepted request to the tracker as a one-hot `trk_requests` vector. It then uses the tracker's `trk_rsp_gnt` to steer the in-order device response back to the master through a one-entry registered response stage. Unmapped addresses go to an internal error responder, which acts as pseudo-device ND.

## Interface
- ND, 3, number of real devices; the paired tracker is instantiated with ND+1 devices.
- AW, 32, address width.
- DW, 32, data width.
- D_BASE, {32'h4000_0000, 32'h0001_0000, 32'h0000_0000}, packed ND*AW base addresses, device 0 in the LSBs.
- D_MASK, {32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000}, packed ND*AW match masks.
- MAX_ERR, 4, maximum number of outstanding unmapped requests.
- g_clk  in  1  clock.
- g_resetn  in  1  reset, synchronous, active-low.
- m_req  in  1  master request valid.
- m_gnt  out  1  master request accepted this cycle.
- m_wen, m_strb, m_addr, m_wdata  in  1, DW/8, AW, DW  master request payload.
- m_recv  out  1  master response valid (registered).
- m_ack  in  1  master accepts the response.
- m_error, m_rdata  out  1, DW  response payload (registered).
- d_req  out  ND  per-device request valid.
- d_gnt  in  ND  per-device request accept.
- d_wen, d_strb, d_addr, d_wdata  out  shared  payload broadcast to all devices.
- d_recv  in  ND  per-device response valid.
- d_ack  out  ND  per-device response accept.
- d_error, d_rdata  in  ND, ND*DW  per-device response payload.
- trk_requests  out  ND+1  one-hot of the request accepted this cycle.
- trk_responses  out  ND+1  one-hot of the response consumed this cycle.
- trk_rsp_gnt  in  ND+1  one-hot owner of the oldest outstanding request.
- trk_ready  in  1  tracker can record a new request.

## Operation
- Decode: `hit[i] = (m_addr & D_MASK[i]) == D_BASE[i]`. On overlap the lowest matching index wins; `sel` is one-hot. If no device hits, the request is unmapped.
- Request path is combinational:
  - `d_req[i] = m_req & sel[i] & trk_ready`.
  - For a mapped address, `m_gnt = |(d_gnt & sel) & trk_ready`.
  - `trk_requests` is `sel` masked by `m_gnt`; bit ND marks an unmapped accept.
- Error responder:
  - Accepts an unmapped request when `m_req & trk_ready & err_pend < MAX_ERR`. The accept asserts `m_gnt` and sets `trk_requests[ND]`.
  - `err_pend` counter, width `$clog2(MAX_ERR+1)`.
  - While `err_pend != 0`, it presents a pseudo-response with error=1 and rdata=0.
- Response stage:
  - Single register with fields rv (valid), re (error) and rd (read data).
  - `free = !rv | m_ack`.
  - The source is the device selected by `trk_rsp_gnt`.
  - `d_ack[i] = trk_rsp_gnt[i] & free`.
  - A capture occurs when `free` and the selected source is valid. On capture, `trk_responses` is set to the selected bit and rv/re/rd load.
  - If `m_ack` with no capture, rv clears.
- `err_pend`: +1 on an unmapped accept, −1 on an error-response capture, unchanged when both occur in the same cycle.
- Responses from devices not selected by `trk_rsp_gnt` are never acked and wait.

## Timing
- Reset values: m_recv=0, m_error=0, m_rdata=0, err_pend=0. All combinational outputs are 0 while m_req=0 and `trk_rsp_gnt` is 0.
- Request latency is 0 cycles, m_req to d_req.
- Response latency is 1 cycle: a device `d_recv` that is captured at edge N is visible on `m_recv` after edge N.
- The response register sustains one response per cycle while `m_ack` is held high.
- `trk_ready=0` blocks all requests. `m_gnt` stays 0 and m_req must hold its payload.
- `err_pend == MAX_ERR` stalls unmapped requests only.
- Reset mid-transaction discards the response register and `err_pend`. Devices are reset on the same g_resetn.

## Configuration
- Macro: IC_ADDR_ROUTER_ERR_EN.
- Defined: error responder present as described.
- Undefined:
  - Unmapped addresses route to device ND-1 as the default slave.
  - `trk_requests[ND]` and `trk_responses[ND]` are tied to 0.
  - `err_pend` logic is removed.

## Test plan
- Read at 0x0001_0004, d_gnt=3'b010 → d_req=3'b010, m_gnt=1, trk_requests=4'b0010; d_rdata[1]=0xCAFE0001 returned with trk_rsp_gnt=4'b0010 → m_recv=1 with rdata=0xCAFE0001 one cycle later.
- trk_ready=0 with m_req to 0x4000_0010 → d_req=0 and m_gnt=0 for 5 cycles; after trk_ready=1, grant in the same cycle.
- Read at 0x2000_0000 with ERR_EN defined → m_gnt=1, trk_requests=4'b1000; with trk_rsp_gnt=4'b1000, m_recv=1, m_error=1, m_rdata=0.
- 5 back-to-back unmapped requests with m_ack=0 → 4 granted, 5th stalled until a response is acked.
- Device 2 asserts d_recv while trk_rsp_gnt=4'b0001 → d_ack[2]=0 until device 0's response is consumed.
- m_ack held at 1 with 3 queued responses → m_recv high for 3 consecutive cycles, correct order, then 0.
